// File: rtl/sweep_max_counter.sv
// Step pacer and brightest-sample tracker for the servo sweep, plus return-to-max counter.
// Optional macro MAX_HYST_EN: a new maximum must beat the current one by more than HYST.
module sweep_max_counter #(
    parameter int STEP_DIV    = 50000,
    parameter int SWEEP_STEPS = 180,
    parameter int ADC_W       = 12,
    parameter int HYST        = 8
) (
    input  logic                                 CLK,
    input  logic                                 RST_N,
    input  logic                                 HS,
    input  logic                                 VS,
    input  logic                                 MC,
    input  logic                                 CNT_RST,
    input  logic [ADC_W-1:0]                     ADC_DATA,
    input  logic                                 ADC_VALID,
    output logic                                 CNT_L,
    output logic                                 CNT_RU,
    output logic                                 CNT_D,
    output logic [$clog2(SWEEP_STEPS+1)-1:0]     POS,
    output logic [ADC_W-1:0]                     MAX_VAL,
    output logic [$clog2(SWEEP_STEPS+1)-1:0]     MAX_POS
);

    localparam int PW = $clog2(SWEEP_STEPS + 1);
    localparam int CW = $clog2(STEP_DIV);

    logic [CW-1:0]    presc_q, presc_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [PW-1:0]    max_pos_q, max_pos_d;
    logic [PW-1:0]    ret_q, ret_d;
    logic [ADC_W-1:0] max_val_q, max_val_d;
    logic [ADC_W-1:0] last_sample_q, last_sample_d;
    logic             cnt_l_q, cnt_l_d;
    logic             cnt_d_q, cnt_d_d;
    logic             cnt_ru_q, cnt_ru_d;
    logic             hs_prev_q, hs_prev_d;
    logic             vs_prev_q, vs_prev_d;
    logic             mc_prev_q, mc_prev_d;

    logic hs_rise, vs_rise, mc_rise, hs_fall, vs_fall, mc_fall;
    logic sweep_active, phase_active, tick, new_max;

    assign hs_rise      = HS & ~hs_prev_q;
    assign vs_rise      = VS & ~vs_prev_q;
    assign mc_rise      = MC & ~mc_prev_q;
    assign hs_fall      = ~HS & hs_prev_q;
    assign vs_fall      = ~VS & vs_prev_q;
    assign mc_fall      = ~MC & mc_prev_q;
    assign sweep_active = cnt_l_q | cnt_d_q;
    assign phase_active = sweep_active | cnt_ru_q;
    assign tick         = phase_active && (presc_q == CW'(STEP_DIV - 1));

`ifdef MAX_HYST_EN
    // Widened by one bit so MAX_VAL+HYST cannot wrap; POS 0 always seeds the maximum.
    assign new_max = (pos_q == '0) ||
                     ({1'b0, last_sample_q} > ({1'b0, max_val_q} + (ADC_W+1)'(HYST)));
`else
    assign new_max = last_sample_q > max_val_q;
`endif

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block leaves a latch.
        presc_d       = presc_q;
        pos_d         = pos_q;
        max_pos_d     = max_pos_q;
        ret_d         = ret_q;
        max_val_d     = max_val_q;
        last_sample_d = last_sample_q;
        cnt_l_d       = cnt_l_q;
        cnt_d_d       = cnt_d_q;
        cnt_ru_d      = cnt_ru_q;
        hs_prev_d     = HS;
        vs_prev_d     = VS;
        mc_prev_d     = MC;

        if (ADC_VALID) begin
            last_sample_d = ADC_DATA;
        end

        if (phase_active) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        if (sweep_active && ((cnt_l_q && hs_fall) || (cnt_d_q && vs_fall))) begin
            cnt_l_d = 1'b0;
            cnt_d_d = 1'b0;
        end else if (cnt_ru_q && mc_fall) begin
            cnt_ru_d = 1'b0;
            ret_d    = '0;
        end else if (tick && sweep_active) begin
            if (new_max) begin
                max_val_d = last_sample_q;
                max_pos_d = pos_q;
            end
            pos_d = pos_q + 1'b1;
            if (pos_q == PW'(SWEEP_STEPS - 1)) begin
                cnt_l_d = 1'b0;
                cnt_d_d = 1'b0;
            end
        end else if (tick && cnt_ru_q) begin
            ret_d = ret_q - 1'b1;
            pos_d = pos_q - 1'b1;
            if (ret_q == PW'(1)) begin
                cnt_ru_d = 1'b0;
            end
        end else if (!phase_active && (hs_rise || vs_rise)) begin
            // HS wins a simultaneous start.
            cnt_l_d   = hs_rise;
            cnt_d_d   = ~hs_rise;
            pos_d     = '0;
            max_val_d = '0;
            max_pos_d = '0;
            presc_d   = '0;
        end else if (!phase_active && mc_rise) begin
            ret_d    = pos_q - max_pos_q;
            cnt_ru_d = (pos_q != max_pos_q);
            presc_d  = '0;
        end

        if (CNT_RST) begin
            presc_d       = '0;
            pos_d         = '0;
            max_pos_d     = '0;
            ret_d         = '0;
            max_val_d     = '0;
            last_sample_d = '0;
            cnt_l_d       = 1'b0;
            cnt_d_d       = 1'b0;
            cnt_ru_d      = 1'b0;
            hs_prev_d     = 1'b0;
            vs_prev_d     = 1'b0;
            mc_prev_d     = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!RST_N) begin
            presc_q       <= '0;
            pos_q         <= '0;
            max_pos_q     <= '0;
            ret_q         <= '0;
            max_val_q     <= '0;
            last_sample_q <= '0;
            cnt_l_q       <= 1'b0;
            cnt_d_q       <= 1'b0;
            cnt_ru_q      <= 1'b0;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            mc_prev_q     <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            pos_q         <= pos_d;
            max_pos_q     <= max_pos_d;
            ret_q         <= ret_d;
            max_val_q     <= max_val_d;
            last_sample_q <= last_sample_d;
            cnt_l_q       <= cnt_l_d;
            cnt_d_q       <= cnt_d_d;
            cnt_ru_q      <= cnt_ru_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            mc_prev_q     <= mc_prev_d;
        end
    end

    assign CNT_L   = cnt_l_q;
    assign CNT_D   = cnt_d_q;
    assign CNT_RU  = cnt_ru_q;
    assign POS     = pos_q;
    assign MAX_VAL = max_val_q;
    assign MAX_POS = max_pos_q;

endmodule

// File: tb/tb_sweep_max_counter.sv
// Directed bench for sweep_max_counter with STEP_DIV=4, SWEEP_STEPS=8, HYST=5.
module tb_sweep_max_counter;

    localparam int STEP_DIV    = 4;
    localparam int SWEEP_STEPS = 8;
    localparam int ADC_W       = 12;
    localparam int PW          = $clog2(SWEEP_STEPS + 1);

    logic             CLK = 1'b0;
    logic             RST_N, HS, VS, MC, CNT_RST, ADC_VALID;
    logic [ADC_W-1:0] ADC_DATA;
    logic             CNT_L, CNT_RU, CNT_D;
    logic [PW-1:0]    POS, MAX_POS;
    logic [ADC_W-1:0] MAX_VAL;

    int n_compared   = 0;
    int n_mismatched = 0;
    int l_cycles = 0, d_cycles = 0, ru_cycles = 0, onehot_err = 0;
    int l_base, d_base, ru_base;
    int samples [8];

    sweep_max_counter #(
        .STEP_DIV(STEP_DIV), .SWEEP_STEPS(SWEEP_STEPS), .ADC_W(ADC_W), .HYST(5)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .HS(HS), .VS(VS), .MC(MC), .CNT_RST(CNT_RST),
        .ADC_DATA(ADC_DATA), .ADC_VALID(ADC_VALID),
        .CNT_L(CNT_L), .CNT_RU(CNT_RU), .CNT_D(CNT_D),
        .POS(POS), .MAX_VAL(MAX_VAL), .MAX_POS(MAX_POS)
    );

    always #5 CLK = ~CLK;

    // Phase-length accounting on the falling edge, away from state changes.
    always @(negedge CLK) begin
        if (CNT_L)  l_cycles  = l_cycles + 1;
        if (CNT_D)  d_cycles  = d_cycles + 1;
        if (CNT_RU) ru_cycles = ru_cycles + 1;
        if (int'(CNT_L) + int'(CNT_D) + int'(CNT_RU) > 1) onehot_err = onehot_err + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_compared = n_compared + 1;
        if (got != exp) begin
            n_mismatched = n_mismatched + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge CLK);
        #1;
    endtask

    // One strobe per step, latched three cycles ahead of that step's tick.
    task automatic run_sweep();
        for (int k = 0; k < SWEEP_STEPS; k++) begin
            ADC_DATA  = ADC_W'(samples[k]);
            ADC_VALID = 1'b1;
            tick_clk();
            ADC_VALID = 1'b0;
            repeat (STEP_DIV - 1) tick_clk();
        end
    endtask

    initial begin
        RST_N = 1'b0; HS = 1'b0; VS = 1'b0; MC = 1'b0; CNT_RST = 1'b0;
        ADC_VALID = 1'b0; ADC_DATA = '0;
        repeat (2) tick_clk();
        check("rst_cnt_l", int'(CNT_L), 0);
        check("rst_pos", int'(POS), 0);
        RST_N = 1'b1;
        tick_clk();

        // Asynchronous reset in the middle of a sweep
        HS = 1'b1;
        tick_clk();
        repeat (8) tick_clk();
        check("pre_rst_pos", int'(POS), 2);
        #3 RST_N = 1'b0;
        #1;
        check("async_rst_cnt_l", int'(CNT_L), 0);
        check("async_rst_pos", int'(POS), 0);
        HS = 1'b0;
        tick_clk();
        RST_N = 1'b1;
        repeat (4) tick_clk();
        check("post_rst_cnt_l", int'(CNT_L), 0);
        check("post_rst_pos", int'(POS), 0);

        // Horizontal sweep then return to max
        samples = '{10, 20, 30, 40, 50, 90, 60, 30};
        l_base = l_cycles;
        HS = 1'b1;
        tick_clk();
        check("h_start_cnt_l", int'(CNT_L), 1);
        run_sweep();
        check("h_cnt_l_cycles", l_cycles - l_base, 32);
        check("h_end_cnt_l", int'(CNT_L), 0);
        check("h_pos", int'(POS), 8);
        check("h_max_val", int'(MAX_VAL), 90);
        check("h_max_pos", int'(MAX_POS), 5);
        HS = 1'b0;
        tick_clk();
        ru_base = ru_cycles;
        MC = 1'b1;
        repeat (16) tick_clk();
        check("ret_cycles", ru_cycles - ru_base, 12);
        check("ret_pos", int'(POS), 5);
        check("ret_end_cnt_ru", int'(CNT_RU), 0);
        MC = 1'b0;
        tick_clk();

        // Tie keeps the first occurrence
        samples = '{10, 20, 50, 30, 40, 20, 50, 10};
        HS = 1'b1;
        tick_clk();
        run_sweep();
        HS = 1'b0;
        check("tie_max_pos", int'(MAX_POS), 2);
        check("tie_max_val", int'(MAX_VAL), 50);
        tick_clk();
        ru_base = ru_cycles;
        MC = 1'b1;
        repeat (28) tick_clk();
        check("tie_ret_cycles", ru_cycles - ru_base, 24);
        check("tie_ret_pos", int'(POS), 2);
        MC = 1'b0;
        tick_clk();

        // Hysteresis-sensitive pattern
        samples = '{10, 50, 20, 30, 54, 10, 20, 30};
        HS = 1'b1;
        tick_clk();
        run_sweep();
        HS = 1'b0;
`ifdef MAX_HYST_EN
        check("hyst_max_pos", int'(MAX_POS), 1);
        check("hyst_max_val", int'(MAX_VAL), 50);
`else
        check("nohyst_max_pos", int'(MAX_POS), 4);
        check("nohyst_max_val", int'(MAX_VAL), 54);
`endif
        tick_clk();

        // Vertical sweep after horizontal
        samples = '{5, 5, 5, 5, 5, 5, 5, 70};
        l_base = l_cycles;
        d_base = d_cycles;
        VS = 1'b1;
        tick_clk();
        check("v_start_max_val", int'(MAX_VAL), 0);
        check("v_start_max_pos", int'(MAX_POS), 0);
        check("v_start_cnt_d", int'(CNT_D), 1);
        run_sweep();
        VS = 1'b0;
        check("v_cnt_d_cycles", d_cycles - d_base, 32);
        check("v_cnt_l_cycles", l_cycles - l_base, 0);
        check("v_max_pos", int'(MAX_POS), 7);
        check("v_max_val", int'(MAX_VAL), 70);
        check("v_pos", int'(POS), 8);
        tick_clk();

        // Simultaneous HS/VS start, then synchronous clear at POS 3
        HS = 1'b1;
        VS = 1'b1;
        tick_clk();
        check("both_cnt_l", int'(CNT_L), 1);
        check("both_cnt_d", int'(CNT_D), 0);
        repeat (12) tick_clk();
        check("clr_pre_pos", int'(POS), 3);
        check("clr_pre_max_val", int'(MAX_VAL), 70);
        CNT_RST = 1'b1;
        HS = 1'b0;
        VS = 1'b0;
        tick_clk();
        CNT_RST = 1'b0;
        check("clr_cnt_l", int'(CNT_L), 0);
        check("clr_pos", int'(POS), 0);
        check("clr_max_val", int'(MAX_VAL), 0);
        ru_base = ru_cycles;
        MC = 1'b1;
        repeat (8) tick_clk();
        check("clr_mc_cnt_ru", int'(CNT_RU), 0);
        check("clr_mc_ru_cycles", ru_cycles - ru_base, 0);
        MC = 1'b0;
        tick_clk();

        // HS falling aborts a sweep and keeps POS
        HS = 1'b1;
        tick_clk();
        repeat (8) tick_clk();
        check("abort_pre_pos", int'(POS), 2);
        HS = 1'b0;
        tick_clk();
        check("abort_cnt_l", int'(CNT_L), 0);
        check("abort_pos", int'(POS), 2);
        repeat (8) tick_clk();
        check("abort_pos_hold", int'(POS), 2);

        check("onehot", onehot_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
